// File: rtl/line_buffer_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : line_buffer_ctrl_if
// Description : Pixel-in, line-buffer-out and window-out signal bundle.
// Revision    : 1.0
// ============================================================================
interface line_buffer_ctrl_if #(
    parameter int BIT_WIDTH = 16,
    parameter int CNT_WIDTH = 8
);
    logic                 in_valid;
    logic [BIT_WIDTH-1:0] in_data;
    logic                 in_ready;
    logic                 lb_valid;
    logic                 lb_zero;
    logic [BIT_WIDTH-1:0] lb_data;
    logic                 win_valid;
    logic [CNT_WIDTH-1:0] win_row;
    logic [CNT_WIDTH-1:0] win_col;
    logic                 out_ready;

    // Controller side
    modport master (
        input  in_valid, in_data, out_ready,
        output in_ready, lb_valid, lb_zero, lb_data, win_valid, win_row, win_col
    );

    // Pixel source / line buffer / window consumer side
    modport slave (
        output in_valid, in_data, out_ready,
        input  in_ready, lb_valid, lb_zero, lb_data, win_valid, win_row, win_col
    );
endinterface
`default_nettype wire

// File: rtl/line_buffer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : line_buffer_ctrl
// Description : Walks the zero-padded map in raster order, feeds the line
//               buffer and flags legal strided convolution windows.
// Revision    : 1.0
// ============================================================================
module line_buffer_ctrl #(
    parameter int KH        = 3,
    parameter int KW        = 3,
    parameter int H         = 5,
    parameter int W         = 5,
    parameter int PAD_H     = 1,
    parameter int PAD_W     = 1,
    parameter int STRIDE    = 1,
    parameter int BIT_WIDTH = 16,
    parameter int CNT_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               busy,
    output logic               frame_done,
    line_buffer_ctrl_if.master bus
);
    localparam int PH = H + 2 * PAD_H;
    localparam int PW = W + 2 * PAD_W;

    localparam logic [CNT_WIDTH-1:0] c_ONE       = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] c_PH_M1     = CNT_WIDTH'(PH - 1);
    localparam logic [CNT_WIDTH-1:0] c_PW_M1     = CNT_WIDTH'(PW - 1);
    localparam logic [CNT_WIDTH-1:0] c_KH_M1     = CNT_WIDTH'(KH - 1);
    localparam logic [CNT_WIDTH-1:0] c_KW_M1     = CNT_WIDTH'(KW - 1);
    localparam logic [CNT_WIDTH-1:0] c_S_M1      = CNT_WIDTH'(STRIDE - 1);
    localparam logic [CNT_WIDTH-1:0] c_PAD_H     = CNT_WIDTH'(PAD_H);
    localparam logic [CNT_WIDTH-1:0] c_PAD_W     = CNT_WIDTH'(PAD_W);
    localparam logic [CNT_WIDTH-1:0] c_PAD_H_END = CNT_WIDTH'(PAD_H + H);
    localparam logic [CNT_WIDTH-1:0] c_PAD_W_END = CNT_WIDTH'(PAD_W + W);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] r_q, r_d, c_q, c_d;
    logic [CNT_WIDTH-1:0] rph_q, rph_d, cph_q, cph_d;
    logic [CNT_WIDTH-1:0] orow_q, orow_d, ocol_q, ocol_d;
    logic [CNT_WIDTH-1:0] win_row_q, win_row_d, win_col_q, win_col_d;
    logic                 win_valid_q, win_valid_d;
    logic                 frame_done_q, frame_done_d;

    logic                 w_pad, w_stall, w_push, w_run, w_qualify, w_last;
    logic [BIT_WIDTH-1:0] w_pix;

    assign w_run     = (state_q == S_RUN);
    assign w_pad     = (r_q < c_PAD_H) | (r_q >= c_PAD_H_END) |
                       (c_q < c_PAD_W) | (c_q >= c_PAD_W_END);
    assign w_stall   = win_valid_q & ~bus.out_ready;
    assign w_push    = w_run & ~w_stall & (w_pad | bus.in_valid);
    // Phase counters sit at zero exactly on rows/cols aligned to the stride grid
    assign w_qualify = (r_q >= c_KH_M1) & (c_q >= c_KW_M1) &
                       (rph_q == '0) & (cph_q == '0);
    assign w_last    = (r_q == c_PH_M1) & (c_q == c_PW_M1);
    assign w_pix     = bus.in_data;

    assign bus.lb_valid  = w_push;
    assign bus.lb_zero   = w_pad & w_push;
    assign bus.lb_data   = w_pix;
    assign bus.in_ready  = w_run & ~w_stall & ~w_pad;
    assign bus.win_valid = win_valid_q;
    assign bus.win_row   = win_row_q;
    assign bus.win_col   = win_col_q;
    assign busy          = (state_q != S_IDLE);
    assign frame_done    = frame_done_q;

    always_comb begin
        state_d      = state_q;
        r_d          = r_q;
        c_d          = c_q;
        rph_d        = rph_q;
        cph_d        = cph_q;
        orow_d       = orow_q;
        ocol_d       = ocol_q;
        win_row_d    = win_row_q;
        win_col_d    = win_col_q;
        win_valid_d  = win_valid_q & ~bus.out_ready;
        frame_done_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    r_d     = '0;
                    c_d     = '0;
                    rph_d   = '0;
                    cph_d   = '0;
                    orow_d  = '0;
                    ocol_d  = '0;
                end
            end
            S_RUN: begin
                if (w_push) begin
                    win_valid_d = w_qualify;
                    win_row_d   = orow_q;
                    win_col_d   = ocol_q;
                    if (w_last) begin
                        state_d = S_DRAIN;
                    end
                    if (c_q == c_PW_M1) begin
                        c_d    = '0;
                        cph_d  = '0;
                        ocol_d = '0;
                        r_d    = r_q + c_ONE;
                        if (r_q >= c_KH_M1) begin
                            if (rph_q == c_S_M1) begin
                                rph_d  = '0;
                                orow_d = orow_q + c_ONE;
                            end else begin
                                rph_d  = rph_q + c_ONE;
                            end
                        end
                    end else begin
                        c_d = c_q + c_ONE;
                        if (c_q >= c_KW_M1) begin
                            if (cph_q == c_S_M1) begin
                                cph_d  = '0;
                                ocol_d = ocol_q + c_ONE;
                            end else begin
                                cph_d  = cph_q + c_ONE;
                            end
                        end
                    end
                end
            end
            S_DRAIN: begin
                // Last window must be consumed before the frame is reported done
                if (!win_valid_q || bus.out_ready) begin
                    state_d      = S_IDLE;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            r_q          <= '0;
            c_q          <= '0;
            rph_q        <= '0;
            cph_q        <= '0;
            orow_q       <= '0;
            ocol_q       <= '0;
            win_row_q    <= '0;
            win_col_q    <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            r_q          <= r_d;
            c_q          <= c_d;
            rph_q        <= rph_d;
            cph_q        <= cph_d;
            orow_q       <= orow_d;
            ocol_q       <= ocol_d;
            win_row_q    <= win_row_d;
            win_col_q    <= win_col_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_line_buffer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_line_buffer_ctrl
// Description : Scoreboard bench for line_buffer_ctrl (stride 1 and stride 2).
// Revision    : 1.0
// ============================================================================
module tb_line_buffer_ctrl;
    localparam int BW = 16;
    localparam int CW = 8;
    localparam int PH = 7;
    localparam int PW = 7;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start0 = 1'b0, busy0, done0;
    logic start1 = 1'b0, busy1, done1;

    line_buffer_ctrl_if #(.BIT_WIDTH(BW), .CNT_WIDTH(CW)) bus0 ();
    line_buffer_ctrl_if #(.BIT_WIDTH(BW), .CNT_WIDTH(CW)) bus1 ();

    line_buffer_ctrl #(.STRIDE(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .busy(busy0),
        .frame_done(done0), .bus(bus0)
    );
    line_buffer_ctrl #(.STRIDE(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1),
        .frame_done(done1), .bus(bus1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0, n_err = 0;

    // stride-1 scoreboard state
    logic [15:0] exp_win[$];
    logic [15:0] exp_pix[$];
    int push_cnt, hs_cnt, win_cnt, done_cnt, first_hs_idx;
    int push16_cyc, first_push_cyc, last_push_cyc, first_win_cyc, last_win_cyc, done_cyc;
    logic        busy_at_done;
    logic [15:0] last_win;
    bit          acc = 1'b0;
    bit          tog = 1'b0;
    logic [15:0] pix = 16'd0;

    // stride-2 scoreboard state
    logic [15:0] exp1[$];
    int push1_cnt = 0, prev1 = -1, win1_cnt = 0, done1_cnt = 0;
    bit w1_after[49];

    function automatic bit pad_at(input int k);
        int r, c;
        r = k / PW;
        c = k % PW;
        return (r < 1) || (r >= PH - 1) || (c < 1) || (c >= PW - 1);
    endfunction

    always @(negedge clk) begin
        logic [15:0] e;
        if (rst_n) begin
            if (bus0.lb_valid) begin
                n_cmp++;
                if (push_cnt >= PH * PW) begin
                    n_err++;
                    $display("FAIL extra_push: push index %0d, required < %0d", push_cnt, PH * PW);
                end else if (bus0.lb_zero !== pad_at(push_cnt)) begin
                    n_err++;
                    $display("FAIL lb_zero: push %0d got %0b expected %0b", push_cnt, bus0.lb_zero, pad_at(push_cnt));
                end
                if (!bus0.lb_zero) begin
                    n_cmp++;
                    if (exp_pix.size() == 0) begin
                        n_err++;
                        $display("FAIL lb_data: push %0d data %0d but no pixel expected", push_cnt, bus0.lb_data);
                    end else begin
                        e = exp_pix.pop_front();
                        if (bus0.lb_data !== e) begin
                            n_err++;
                            $display("FAIL lb_data: push %0d got %0d expected %0d", push_cnt, bus0.lb_data, e);
                        end
                    end
                end
                if (push_cnt == 16) push16_cyc = cyc;
                if (first_push_cyc < 0) first_push_cyc = cyc;
                last_push_cyc = cyc;
                if (bus0.in_valid && bus0.in_ready && first_hs_idx < 0) first_hs_idx = push_cnt;
                push_cnt++;
            end
            if (bus0.in_valid && bus0.in_ready) hs_cnt++;
            acc = bus0.in_valid && bus0.in_ready;
            if (bus0.win_valid && first_win_cyc < 0) first_win_cyc = cyc;
            if (bus0.win_valid && bus0.out_ready) begin
                n_cmp++;
                if (exp_win.size() == 0) begin
                    n_err++;
                    $display("FAIL window: got (%0d,%0d) but none expected", bus0.win_row, bus0.win_col);
                end else begin
                    e = exp_win.pop_front();
                    if ({bus0.win_row, bus0.win_col} !== e) begin
                        n_err++;
                        $display("FAIL window: got (%0d,%0d) expected (%0d,%0d)", bus0.win_row, bus0.win_col, e[15:8], e[7:0]);
                    end
                end
                last_win     = {bus0.win_row, bus0.win_col};
                last_win_cyc = cyc;
                win_cnt++;
            end
            if (done0) begin
                done_cnt++;
                done_cyc     = cyc;
                busy_at_done = busy0;
            end
        end else begin
            acc = 1'b0;
        end
    end

    always @(negedge clk) begin
        logic [15:0] e;
        if (rst_n) begin
            if (prev1 >= 0 && prev1 < 49) w1_after[prev1] = bus1.win_valid;
            prev1 = bus1.lb_valid ? push1_cnt : -1;
            if (bus1.lb_valid) push1_cnt++;
            if (bus1.win_valid && bus1.out_ready) begin
                n_cmp++;
                if (exp1.size() == 0) begin
                    n_err++;
                    $display("FAIL s2_window: got (%0d,%0d) but none expected", bus1.win_row, bus1.win_col);
                end else begin
                    e = exp1.pop_front();
                    if ({bus1.win_row, bus1.win_col} !== e) begin
                        n_err++;
                        $display("FAIL s2_window: got (%0d,%0d) expected (%0d,%0d)", bus1.win_row, bus1.win_col, e[15:8], e[7:0]);
                    end
                end
                win1_cnt++;
            end
            if (done1) done1_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (acc) pix = pix + 16'd1;
        bus0.in_data = pix;
        if (tog) bus0.in_valid = ~bus0.in_valid;
    endtask

    task automatic begin_frame();
        exp_win.delete();
        exp_pix.delete();
        push_cnt = 0; hs_cnt = 0; win_cnt = 0; done_cnt = 0; first_hs_idx = -1;
        push16_cyc = -1; first_push_cyc = -1; last_push_cyc = -1;
        first_win_cyc = -1; last_win_cyc = -1; done_cyc = -1;
        busy_at_done = 1'bx; last_win = 16'hxxxx;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) exp_win.push_back({8'(r), 8'(c)});
        for (int i = 1; i <= 25; i++) exp_pix.push_back(16'(i));
        pix = 16'd1;
        bus0.in_data = pix;
        start0 = 1'b1;
        step();
        start0 = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 400 && done_cnt == 0; i++) step();
        n_cmp++;
        if (done_cnt == 0) begin
            n_err++;
            $display("FAIL %s_timeout: frame_done not seen in 400 cycles, windows=%0d", name, win_cnt);
        end
    endtask

    task automatic test_reset();
        repeat (3) step();
        n_cmp++;
        if ({bus0.win_valid, busy0, done0, bus0.lb_valid, bus0.in_ready} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_flags: got %b expected 00000", {bus0.win_valid, busy0, done0, bus0.lb_valid, bus0.in_ready});
        end
        n_cmp++;
        if ({bus0.win_row, bus0.win_col} !== 16'h0) begin
            n_err++;
            $display("FAIL reset_coords: got %h expected 0000", {bus0.win_row, bus0.win_col});
        end
        rst_n = 1'b1;
        repeat (2) step();
    endtask

    task automatic test_basic();
        begin_frame();
        wait_done("basic");
        n_cmp++; if (push_cnt !== 49) begin n_err++; $display("FAIL basic_pushes: got %0d expected 49", push_cnt); end
        n_cmp++; if (last_push_cyc - first_push_cyc !== 48) begin n_err++; $display("FAIL basic_push_span: got %0d cycles expected 48", last_push_cyc - first_push_cyc); end
        n_cmp++; if (hs_cnt !== 25) begin n_err++; $display("FAIL basic_handshakes: got %0d expected 25", hs_cnt); end
        n_cmp++; if (first_hs_idx !== 8) begin n_err++; $display("FAIL basic_first_hs: got push %0d expected 8", first_hs_idx); end
        n_cmp++; if (first_win_cyc !== push16_cyc + 1) begin n_err++; $display("FAIL basic_win_latency: got cycle %0d expected %0d", first_win_cyc, push16_cyc + 1); end
        n_cmp++; if (win_cnt !== 25) begin n_err++; $display("FAIL basic_windows: got %0d expected 25", win_cnt); end
        n_cmp++; if (last_win !== 16'h0404) begin n_err++; $display("FAIL basic_last_win: got %h expected 0404", last_win); end
        n_cmp++; if (done_cyc !== last_win_cyc + 1) begin n_err++; $display("FAIL basic_done_time: got cycle %0d expected %0d", done_cyc, last_win_cyc + 1); end
        n_cmp++; if (busy_at_done !== 1'b0) begin n_err++; $display("FAIL basic_busy_at_done: got %b expected 0", busy_at_done); end
    endtask

    task automatic test_backpressure();
        bit found = 1'b0;
        begin_frame();
        for (int i = 0; i < 100 && !found; i++) begin
            step();
            found = bus0.win_valid;
        end
        n_cmp++;
        if (!found) begin
            n_err++;
            $display("FAIL bp_first_window: win_valid not seen within 100 cycles");
        end
        bus0.out_ready = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step();
            n_cmp++;
            if ({bus0.win_valid, bus0.lb_valid, bus0.in_ready} !== 3'b100) begin
                n_err++;
                $display("FAIL bp_hold_flags: stall cycle %0d got %b expected 100", i, {bus0.win_valid, bus0.lb_valid, bus0.in_ready});
            end
            n_cmp++;
            if ({bus0.win_row, bus0.win_col} !== 16'h0000) begin
                n_err++;
                $display("FAIL bp_hold_coords: stall cycle %0d got %h expected 0000", i, {bus0.win_row, bus0.win_col});
            end
        end
        bus0.out_ready = 1'b1;
        #1;
        n_cmp++;
        if ({bus0.lb_valid, bus0.in_ready} !== 2'b11) begin
            n_err++;
            $display("FAIL bp_resume: got %b expected 11", {bus0.lb_valid, bus0.in_ready});
        end
        wait_done("bp");
        n_cmp++; if (win_cnt !== 25) begin n_err++; $display("FAIL bp_windows: got %0d expected 25", win_cnt); end
        n_cmp++; if (push_cnt !== 49) begin n_err++; $display("FAIL bp_pushes: got %0d expected 49", push_cnt); end
    endtask

    task automatic test_toggle();
        tog = 1'b1;
        begin_frame();
        wait_done("toggle");
        tog = 1'b0;
        bus0.in_valid = 1'b1;
        n_cmp++; if (hs_cnt !== 25) begin n_err++; $display("FAIL toggle_handshakes: got %0d expected 25", hs_cnt); end
        n_cmp++; if (win_cnt !== 25) begin n_err++; $display("FAIL toggle_windows: got %0d expected 25", win_cnt); end
        n_cmp++; if (push_cnt !== 49) begin n_err++; $display("FAIL toggle_pushes: got %0d expected 49", push_cnt); end
        n_cmp++; if (exp_pix.size() !== 0) begin n_err++; $display("FAIL toggle_pixels_left: got %0d expected 0", exp_pix.size()); end
    endtask

    task automatic test_stride2();
        int r2, c2;
        exp1.delete();
        push1_cnt = 0; prev1 = -1; win1_cnt = 0; done1_cnt = 0;
        for (int i = 0; i < 49; i++) w1_after[i] = 1'b0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) exp1.push_back({8'(r), 8'(c)});
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        for (int i = 0; i < 300 && done1_cnt == 0; i++) step();
        n_cmp++; if (done1_cnt == 0) begin n_err++; $display("FAIL s2_timeout: frame_done not seen in 300 cycles"); end
        n_cmp++; if (win1_cnt !== 9) begin n_err++; $display("FAIL s2_windows: got %0d expected 9", win1_cnt); end
        n_cmp++; if (w1_after[16] !== 1'b1) begin n_err++; $display("FAIL s2_win_after_2_2: got %b expected 1", w1_after[16]); end
        n_cmp++; if (w1_after[24] !== 1'b0) begin n_err++; $display("FAIL s2_win_after_3_3: got %b expected 0", w1_after[24]); end
        n_cmp++; if (w1_after[23] !== 1'b0) begin n_err++; $display("FAIL s2_win_after_3_2: got %b expected 0", w1_after[23]); end
        n_cmp++; if (w1_after[48] !== 1'b1) begin n_err++; $display("FAIL s2_win_after_6_6: got %b expected 1", w1_after[48]); end
        r2 = 0;
        c2 = 0;
    endtask

    task automatic test_midreset();
        begin_frame();
        for (int i = 0; i < 100 && push_cnt < 20; i++) step();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus0.win_valid, busy0, done0, bus0.lb_valid, bus0.in_ready} !== 5'b0) begin
            n_err++;
            $display("FAIL midrst_flags: got %b expected 00000", {bus0.win_valid, busy0, done0, bus0.lb_valid, bus0.in_ready});
        end
        n_cmp++;
        if ({bus0.win_row, bus0.win_col} !== 16'h0) begin
            n_err++;
            $display("FAIL midrst_coords: got %h expected 0000", {bus0.win_row, bus0.win_col});
        end
        repeat (2) step();
        rst_n = 1'b1;
        step();
        begin_frame();
        wait_done("midrst");
        n_cmp++; if (win_cnt !== 25) begin n_err++; $display("FAIL midrst_windows: got %0d expected 25", win_cnt); end
        n_cmp++; if (push_cnt !== 49) begin n_err++; $display("FAIL midrst_pushes: got %0d expected 49", push_cnt); end
    endtask

    task automatic test_start_in_run();
        begin_frame();
        repeat (10) step();
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        wait_done("restart");
        n_cmp++; if (win_cnt !== 25) begin n_err++; $display("FAIL restart_windows: got %0d expected 25", win_cnt); end
        n_cmp++; if (push_cnt !== 49) begin n_err++; $display("FAIL restart_pushes: got %0d expected 49", push_cnt); end
        n_cmp++; if (hs_cnt !== 25) begin n_err++; $display("FAIL restart_handshakes: got %0d expected 25", hs_cnt); end
    endtask

    initial begin
        bus0.in_valid  = 1'b1;
        bus0.in_data   = 16'd0;
        bus0.out_ready = 1'b1;
        bus1.in_valid  = 1'b1;
        bus1.in_data   = 16'd7;
        bus1.out_ready = 1'b1;
        test_reset();
        test_basic();
        test_backpressure();
        test_toggle();
        test_stride2();
        test_midreset();
        test_start_in_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
`default_nettype wire
